// File: rtl/add_pipe_pkg.sv
// ============================================================================
// add_pipe_pkg: shared defaults and result entry type for the adder pipeline.
// Revision 1.0
// ============================================================================
`default_nettype none

package add_pipe_pkg;

    localparam int C_DATA_W = 64;
    localparam int C_DEPTH  = 4;

    typedef struct packed {
        logic                cout;
        logic [C_DATA_W-1:0] sum;
    } add_entry_t;

endpackage

`default_nettype wire

// File: rtl/result_fifo_mem.sv
// ============================================================================
// result_fifo_mem: storage array, one clocked write port, one async read port.
// Revision 1.0
// ============================================================================
`default_nettype none

module result_fifo_mem #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/add_result_fifo.sv
// ============================================================================
// add_result_fifo: first-word-fall-through buffer for adder results; drops
// results when full. Optional counters: ADD_RESULT_FIFO_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module add_result_fifo
    import add_pipe_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W,
    parameter int DEPTH     = C_DEPTH,
    parameter int AFULL_LVL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_sum,
    input  logic                       in_cout,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_sum,
    output logic                       out_cout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow
`ifdef ADD_RESULT_FIFO_STATS_EN
    ,
    output logic [31:0]                result_cnt,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic              cout;
        logic [DATA_W-1:0] sum;
    } entry_t;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic   w_full;
    logic   w_pop;
    logic   w_push;
    logic   w_drop;
    entry_t w_wr_entry;
    entry_t w_rd_entry;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    assign w_wr_entry.cout = in_cout;
    assign w_wr_entry.sum  = in_sum;

    result_fifo_mem #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push && !rst),
        .waddr (r_wr_ptr),
        .wdata (w_wr_entry),
        .raddr (r_rd_ptr),
        .rdata (w_rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_sum     = w_rd_entry.sum;
    assign out_cout    = w_rd_entry.cout;
    assign count       = r_count;
    assign almost_full = (r_count >= CW'(AFULL_LVL));
    assign overflow    = r_overflow;

`ifdef ADD_RESULT_FIFO_STATS_EN
    logic [31:0] r_result_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_result_cnt <= r_result_cnt + 32'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign result_cnt = r_result_cnt;
    assign drop_cnt   = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_result_fifo.sv
// ============================================================================
// tb_add_result_fifo: directed vector table plus hand sequences for the FIFO.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_add_result_fifo;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_sum;
    logic        in_cout;
    logic        clr_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic [2:0]  count;
    logic        almost_full;
    logic        overflow;
`ifdef ADD_RESULT_FIFO_STATS_EN
    logic [31:0] result_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_result_fifo #(
        .DATA_W    (64),
        .DEPTH     (4),
        .AFULL_LVL (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sum      (in_sum),
        .in_cout     (in_cout),
        .clr_ovf     (clr_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
`ifdef ADD_RESULT_FIFO_STATS_EN
        ,
        .result_cnt  (result_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [63:0] s;
        logic        c;
        logic        r;
        logic        k;
        logic        ev;
        logic [63:0] es;
        logic        ec;
        logic [2:0]  ecnt;
        logic        eaf;
        logic        eov;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] s, input logic c,
                         input logic r, input logic k);
        in_valid  = v;
        in_sum    = s;
        in_cout   = c;
        out_ready = r;
        clr_ovf   = k;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [63:0] es,
                               input logic ec, input logic [2:0] ecnt,
                               input logic eaf, input logic eov);
        chk({tag, " out_valid"}, {63'd0, out_valid}, {63'd0, ev});
        chk({tag, " count"}, {61'd0, count}, {61'd0, ecnt});
        chk({tag, " almost_full"}, {63'd0, almost_full}, {63'd0, eaf});
        chk({tag, " overflow"}, {63'd0, overflow}, {63'd0, eov});
        if (ev) begin
            chk({tag, " out_sum"}, out_sum, es);
            chk({tag, " out_cout"}, {63'd0, out_cout}, {63'd0, ec});
        end
    endtask

    initial begin
        //          v  s                      c  r  k   ev es                     ec cnt   af eov
        tbl[0]  = '{H, 64'h1,                 L, L, L,  H, 64'h1,                 L, 3'd1, L, L};
        tbl[1]  = '{L, 64'h0,                 L, H, L,  L, 64'h0,                 L, 3'd0, L, L};
        tbl[2]  = '{H, 64'hA,                 L, L, L,  H, 64'hA,                 L, 3'd1, L, L};
        tbl[3]  = '{H, 64'hB,                 L, L, L,  H, 64'hA,                 L, 3'd2, H, L};
        tbl[4]  = '{H, 64'hC,                 L, L, L,  H, 64'hA,                 L, 3'd3, H, L};
        tbl[5]  = '{H, 64'hD,                 L, L, L,  H, 64'hA,                 L, 3'd4, H, L};
        tbl[6]  = '{H, 64'hFFFF_FFFF_FFFF_FFFF, H, H, L, H, 64'hB,                L, 3'd4, H, L};
        tbl[7]  = '{H, 64'h55,                L, L, L,  H, 64'hB,                 L, 3'd4, H, H};
        tbl[8]  = '{H, 64'h66,                L, L, H,  H, 64'hB,                 L, 3'd4, H, H};
        tbl[9]  = '{L, 64'h0,                 L, L, H,  H, 64'hB,                 L, 3'd4, H, L};
        tbl[10] = '{L, 64'h0,                 L, H, L,  H, 64'hC,                 L, 3'd3, H, L};
        tbl[11] = '{L, 64'h0,                 L, H, L,  H, 64'hD,                 L, 3'd2, H, L};
        tbl[12] = '{L, 64'h0,                 L, H, L,  H, 64'hFFFF_FFFF_FFFF_FFFF, H, 3'd1, L, L};
        tbl[13] = '{L, 64'h0,                 L, H, L,  L, 64'h0,                 L, 3'd0, L, L};

        // Reset held for two cycles with in_valid high; it must be ignored.
        rst = 1'b1;
        drive(H, 64'h77, L, L, L);
        tick();
        tick();
        check_state("reset", L, 64'h0, L, 3'd0, L, L);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].k);
            tick();
            check_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ec,
                        tbl[i].ecnt, tbl[i].eaf, tbl[i].eov);
        end
`ifdef ADD_RESULT_FIFO_STATS_EN
        chk("result_cnt after table", {32'd0, result_cnt}, 64'd6);
        chk("drop_cnt after table", {48'd0, drop_cnt}, 64'd2);
`endif

        // Streaming: two preloaded entries, then simultaneous push/pop with pointer wrap.
        drive(H, 64'h100, L, L, L);
        tick();
        drive(H, 64'h101, H, L, L);
        tick();
        check_state("preload", H, 64'h100, L, 3'd2, H, L);
        for (int i = 0; i < 10; i++) begin
            drive(H, 64'h102 + 64'(i), i[0], H, L);
            tick();
            check_state($sformatf("stream%0d", i), H, 64'h101 + 64'(i),
                        ~i[0], 3'd2, H, L);
        end
        drive(L, 64'h0, L, H, L);
        tick();
        check_state("drain0", H, 64'h10B, H, 3'd1, L, L);
        tick();
        check_state("drain1", L, 64'h0, L, 3'd0, L, L);
`ifdef ADD_RESULT_FIFO_STATS_EN
        chk("result_cnt after stream", {32'd0, result_cnt}, 64'd18);
`endif

        // Reset mid-operation with three entries and in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            drive(H, 64'h200 + 64'(i), L, L, L);
            tick();
        end
        check_state("pre_rst", H, 64'h200, L, 3'd3, H, L);
        rst = 1'b1;
        drive(H, 64'h300, L, L, L);
        tick();
        check_state("mid_rst", L, 64'h0, L, 3'd0, L, L);
        rst = 1'b0;
        drive(L, 64'h0, L, L, L);
        tick();
        check_state("post_rst", L, 64'h0, L, 3'd0, L, L);
`ifdef ADD_RESULT_FIFO_STATS_EN
        chk("result_cnt after rst", {32'd0, result_cnt}, 64'd0);
        chk("drop_cnt after rst", {48'd0, drop_cnt}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add_result_fifo.md
ADD_RESULT_FIFO -- requirements
Module: add_result_fifo

Interface
REQ-001 Parameter DATA_W, default 64, sum width from the adder pipeline.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 Parameter AFULL_LVL, default 2, count at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  sum/cout from the adder output register valid this cycle.
REQ-007 in_sum  input  DATA_W  adder sum.
REQ-008 in_cout  input  1  adder carry-out.
REQ-009 clr_ovf  input  1  clears sticky overflow.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer accepts head this cycle.
REQ-012 out_sum  output  DATA_W  head entry sum.
REQ-013 out_cout  output  1  head entry carry-out.
REQ-014 count  output  $clog2(DEPTH)+1  stored entries.
REQ-015 almost_full  output  1  count >= AFULL_LVL; upstream stops issuing operands.
REQ-016 overflow  output  1  sticky: an input result was dropped.

Function
REQ-017 Block is the downstream consumer of the 2-cycle registered adder; the adder cannot stall, so in_valid is never back-pressured.
REQ-018 First-word-fall-through: out_valid = (count != 0); out_sum/out_cout driven combinationally from the head entry.
REQ-019 Pop occurs when out_valid && out_ready; read pointer advances modulo DEPTH.
REQ-020 Push occurs when in_valid && (count < DEPTH || pop); {in_cout,in_sum} written at write pointer, pointer advances modulo DEPTH.
REQ-021 Push and pop in the same cycle leave count unchanged, including when count == DEPTH.
REQ-022 in_valid with count == DEPTH and no pop drops the data, sets overflow, leaves contents, pointers and count unchanged.
REQ-023 Written entry is visible on out_* the cycle after the push (one-cycle fall-through latency when empty).
REQ-024 When out_valid is low, out_sum/out_cout are don't-care; bench checks them only when out_valid is high.
REQ-025 overflow set has priority over clr_ovf in the same cycle.
REQ-026 almost_full and count are registered-state derived, no combinational path from in_valid or out_ready.

Reset
REQ-027 On rst: pointers 0, count 0, out_valid 0, almost_full 0, overflow 0; storage contents not reset.
REQ-028 rst mid-operation discards all stored entries; in_valid during rst is ignored and does not set overflow.

Configuration
REQ-029 With ADD_RESULT_FIFO_STATS_EN defined: extra outputs result_cnt (32 bits, increments per accepted push) and drop_cnt (16 bits, increments per dropped input, saturates at 0xFFFF); both reset to 0 by rst only.
REQ-030 Without ADD_RESULT_FIFO_STATS_EN: ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package add_pipe_pkg holds DATA_W default, DEPTH default and the entry typedef {cout, sum[DATA_W-1:0]}.
REQ-032 Storage array is one sub-module, result_fifo_mem: 1 write port (clocked), 1 asynchronous read port; pointer/count/flag logic stays in add_result_fifo.

Verification
REQ-033 rst, then push 0x0000_0000_0000_0001/cout 0 -> next cycle out_valid 1, out_sum 0x1, count 1.
REQ-034 Push 4 entries 0xA..0xD with out_ready 0 -> count 4, almost_full 1 from count 2; pops with out_ready 1 return 0xA,0xB,0xC,0xD in order, then out_valid 0.
REQ-035 Full FIFO, in_valid 1 and out_ready 1 same cycle with sum 0xFFFF_FFFF_FFFF_FFFF cout 1 -> count stays 4, overflow 0, new entry emerges last.
REQ-036 Full FIFO, in_valid 1, out_ready 0 -> overflow 1, contents unchanged; clr_ovf 1 next cycle -> overflow 0; with STATS_EN drop_cnt 1.
REQ-037 Continuous push/pop for 10 cycles (pointer wrap twice) -> output sequence equals input sequence, count constant.
REQ-038 rst asserted with count 3 and in_valid 1 -> next cycle count 0, out_valid 0, overflow 0.
